// File: rtl/mem_ctrl.sv
// Request-side master for a synchronous 8x32 memory.
// Requests are queued in a small FIFO and issued one at a time. Read data is returned on a response port.
module mem_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, RESP} state_t;

  // FIFO storage carries no reset; only the pointers and count define its contents.
  logic              fifo_wr_mem   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;

  logic              push;
  logic              pop;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign req_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = req_valid & req_ready;
  assign head_write = fifo_wr_mem[rd_ptr_q];
  assign head_addr  = fifo_addr_mem[rd_ptr_q];
  assign head_data  = fifo_data_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_mem[wr_ptr_q]   <= req_write;
      fifo_addr_mem[wr_ptr_q] <= req_addr;
      fifo_data_mem[wr_ptr_q] <= req_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          mem_addr_d = head_addr;
          if (head_write) begin
            mem_wdata_d = head_data;
            mem_write_d = 1'b1;
            state_d     = WRITE;
          end else begin
            mem_read_d = 1'b1;
            state_d    = READ;
          end
        end
      end
      WRITE: begin
        mem_write_d = 1'b0;
        state_d     = IDLE;
      end
      READ: begin
        mem_read_d = 1'b0;
        state_d    = RWAIT;
      end
      RWAIT: begin
        // memory output register now holds the addressed word
        rsp_data_d  = mem_rdata;
        rsp_addr_d  = mem_addr_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign busy      = (count_q != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised bench for mem_ctrl with an attached 8x32 memory.
// Expected read data comes from an array of accepted writes plus an in-order queue of reads.
module tb_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [4:0] rsp_addr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_read;
  logic       mem_write;
  logic       busy;

  logic       rsp_ready_man = 1'b1;
  logic       rsp_rand = 1'b0;
  logic       rand_bit = 1'b1;
  assign rsp_ready = rsp_rand ? rand_bit : rsp_ready_man;

  int n_checks = 0;
  int n_errors = 0;
  int rd_strobes = 0;
  int wr_strobes = 0;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] ref_mem [32];
  logic [7:0] mem_arr [32];

  always #5 clk = ~clk;

  mem_ctrl #(.DATA_W(8), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .busy(busy)
  );

  // Synchronous memory with registered read data.
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem_arr[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 rand_bit = 1'($urandom_range(0, 1));
    end
  end

  // Response scoreboard, strobe counters and hold-stability checks.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic [4:0] prev_addr;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (mem_read) rd_strobes++;
      if (mem_write) wr_strobes++;
      if (mem_read || mem_write) check("strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
      if (prev_hold) begin
        check("hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_data", {24'd0, rsp_data}, {24'd0, prev_data});
        check("hold_addr", {27'd0, rsp_addr}, {27'd0, prev_addr});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_data", {24'd0, rsp_data}, {24'd0, e.d});
          check("rsp_addr", {27'd0, rsp_addr}, {27'd0, e.a});
        end
      end
      prev_hold = rsp_valid & ~rsp_ready;
      prev_data = rsp_data;
      prev_addr = rsp_addr;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic w, input logic [4:0] a, input logic [7:0] d);
    int n;
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    if (w) begin
      ref_mem[a] = d;
    end else begin
      e.a = a;
      e.d = ref_mem[a];
      exp_q.push_back(e);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || rsp_valid || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rsp_valid_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0;
    int w0;
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Reset with one read pending in RESP and three queued behind it.
    rsp_ready_man = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 5'(i + 4), 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy_mid", {31'd0, busy}, 32'd0);
    check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_addr", {27'd0, rsp_addr}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready_man = 1'b1;
    check("rst_req_ready2", {31'd0, req_ready}, 32'd1);
    repeat (20) @(posedge clk);
    #1 check("rst_no_rsp", {31'd0, busy | rsp_valid}, 32'd0);

    // Write then read back the same address.
    r0 = rd_strobes;
    w0 = wr_strobes;
    push(1'b1, 5'd3, 8'hA5);
    push(1'b0, 5'd3, 8'h00);
    wait_idle();
    check("t2_rd_pulses", 32'(rd_strobes - r0), 32'd1);
    check("t2_wr_pulses", 32'(wr_strobes - w0), 32'd1);

    // FIFO fills while the FSM is held in RESP.
    rsp_ready_man = 1'b0;
    push(1'b0, 5'd3, 8'h00);
    wait_rsp_valid();
    for (int i = 0; i < 4; i++) push(1'b1, 5'(8 + i), 8'(8'h30 + i));
    check("t3_full", {31'd0, req_ready}, 32'd0);
    fork
      push(1'b1, 5'd12, 8'h34);
      begin
        repeat (6) @(posedge clk);
        #1 check("t3_full_hold", {31'd0, req_ready}, 32'd0);
        rsp_ready_man = 1'b1;
      end
    join
    for (int i = 0; i < 5; i++) push(1'b0, 5'(8 + i), 8'h00);
    wait_idle();

    // Response stalled: second read must not strobe until the handshake.
    rsp_ready_man = 1'b0;
    r0 = rd_strobes;
    push(1'b0, 5'd31, 8'h00);
    push(1'b0, 5'd0, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    check("t4_rd_pulses", 32'(rd_strobes - r0), 32'd1);
    check("t4_rsp_addr", {27'd0, rsp_addr}, 32'd31);
    rsp_ready_man = 1'b1;
    wait_idle();
    check("t4_rd_pulses2", 32'(rd_strobes - r0), 32'd2);

    // Fill the whole memory and read it back.
    for (int i = 0; i < 32; i++) push(1'b1, 5'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 32; i++) push(1'b0, 5'(i), 8'h00);
    wait_idle();

    // Push lands on the same edge as a pop with three entries queued.
    rsp_ready_man = 1'b0;
    push(1'b0, 5'd1, 8'h00);
    wait_rsp_valid();
    for (int i = 0; i < 3; i++) push(1'b1, 5'(20 + i), 8'(8'hC0 + i));
    check("t6_not_full", {31'd0, req_ready}, 32'd1);
    rsp_ready_man = 1'b1;
    @(posedge clk);
    #1;
    push(1'b1, 5'd23, 8'hC3);
    check("t6_count_same", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) push(1'b0, 5'(20 + i), 8'h00);
    wait_idle();

    // Random traffic with random response back-pressure.
    rsp_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      push(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    rsp_rand = 1'b0;
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
